// File: rtl/cpu_pkg.sv
// Shared widths, enums and the fault-classification helper for the writeback stage.
package cpu_pkg;

    localparam int ADDR_WIDTH              = 32;
    localparam int DATA_WIDTH              = 32;
    localparam int REGISTER_INDEXING_WIDTH = 5;
    localparam int RETIRE_COUNT_WIDTH      = 64;

    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'd0,
        CAUSE_ILLEGAL      = 2'd1,
        CAUSE_ENVIRONMENT  = 2'd2,
        CAUSE_MISSING_DATA = 2'd3
    } halt_cause_t;

    typedef enum logic {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]              pc;
        logic                               pc_valid;
        logic                               opcode_legal;
        logic                               environment;
        logic                               load;
        logic                               store;
        logic [REGISTER_INDEXING_WIDTH-1:0] write_register;
        logic                               write_register_valid;
        logic [DATA_WIDTH-1:0]              result_data;
        logic                               result_data_valid;
    } wb_entry_t;

    // Highest-priority reason an entry cannot retire; CAUSE_NONE when it can.
    function automatic halt_cause_t fault_cause(input wb_entry_t e);
        if (!e.opcode_legal)
            return CAUSE_ILLEGAL;
        else if (e.environment)
            return CAUSE_ENVIRONMENT;
        else if (e.write_register_valid && !e.result_data_valid)
            return CAUSE_MISSING_DATA;
        else
            return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage handoff: offer/stall handshake plus the decoded entry.
interface writeback_stage_if;

    logic                                        prev_done;
    logic                                        stall_prev;
    logic [cpu_pkg::ADDR_WIDTH-1:0]              program_count_in;
    logic                                        program_count_valid_in;
    logic                                        opcode_legal_in;
    logic                                        environment_in;
    logic                                        load_in;
    logic                                        store_in;
    logic [cpu_pkg::REGISTER_INDEXING_WIDTH-1:0] write_register_in;
    logic                                        write_register_valid_in;
    logic [cpu_pkg::DATA_WIDTH-1:0]              result_data_in;
    logic                                        result_data_valid_in;

    modport master (
        output prev_done, program_count_in, program_count_valid_in,
               opcode_legal_in, environment_in, load_in, store_in,
               write_register_in, write_register_valid_in,
               result_data_in, result_data_valid_in,
        input  stall_prev
    );

    modport slave (
        input  prev_done, program_count_in, program_count_valid_in,
               opcode_legal_in, environment_in, load_in, store_in,
               write_register_in, write_register_valid_in,
               result_data_in, result_data_valid_in,
        output stall_prev
    );

endinterface

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter; wraps silently at the top of its range.
module retire_counter
    import cpu_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc,
    output logic [RETIRE_COUNT_WIDTH-1:0] count
);

    logic [RETIRE_COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else if (inc)
            count_q <= count_q + 1'b1;
    end

    assign count = count_q;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: holds one entry per cycle, writes the register file, retires or halts on fault.
//   state     | meaning
//   WB_RUN    | accepting entries, writing back and retiring
//   WB_HALTED | faulted; refusing entries until a resume pulse
module writeback_stage
    import cpu_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    writeback_stage_if.slave                   mem,
    input  logic                               resume,
    output logic                               rf_write_enable,
    output logic [REGISTER_INDEXING_WIDTH-1:0] rf_write_index,
    output logic [DATA_WIDTH-1:0]              rf_write_data,
    output logic                               fwd_valid,
    output logic [REGISTER_INDEXING_WIDTH-1:0] fwd_register,
    output logic [DATA_WIDTH-1:0]              fwd_data,
    output logic [RETIRE_COUNT_WIDTH-1:0]      retired_count,
    output logic                               halted,
    output logic [ADDR_WIDTH-1:0]              halt_pc,
    output halt_cause_t                        halt_cause
);

    wb_entry_t   entry_q;
    wb_entry_t   entry_in;
    logic        has_input_q;
    wb_state_t   state_q;
    logic [ADDR_WIDTH-1:0] halt_pc_q;
    halt_cause_t halt_cause_q;

    halt_cause_t entry_cause;
    logic        fault;
    logic        stall;
    logic        transfer;
    logic        retire;
    logic        write_ok;

    assign entry_in = '{
        pc:                   mem.program_count_in,
        pc_valid:             mem.program_count_valid_in,
        opcode_legal:         mem.opcode_legal_in,
        environment:          mem.environment_in,
        load:                 mem.load_in,
        store:                mem.store_in,
        write_register:       mem.write_register_in,
        write_register_valid: mem.write_register_valid_in,
        result_data:          mem.result_data_in,
        result_data_valid:    mem.result_data_valid_in
    };

    assign entry_cause = fault_cause(entry_q);
    assign fault       = has_input_q && (entry_cause != CAUSE_NONE);
    assign stall       = rst || (state_q == WB_HALTED) || fault;
    assign transfer    = mem.prev_done && !stall;
    assign retire      = !rst && (state_q == WB_RUN) && has_input_q && !fault;

    // Writes to x0 are dropped but the instruction still retires.
    assign write_ok = retire && entry_q.write_register_valid
                      && (entry_q.write_register != '0);

    assign mem.stall_prev  = stall;
    assign rf_write_enable = write_ok;
    assign rf_write_index  = entry_q.write_register;
    assign rf_write_data   = entry_q.result_data;
    assign fwd_valid       = write_ok;
    assign fwd_register    = entry_q.write_register;
    assign fwd_data        = entry_q.result_data;
    assign halted          = !rst && (state_q == WB_HALTED);
    assign halt_pc         = halt_pc_q;
    assign halt_cause      = halt_cause_q;

    // Entry payload is only meaningful while has_input_q is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (transfer)
            entry_q <= entry_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WB_RUN;
            has_input_q  <= 1'b0;
            halt_pc_q    <= '0;
            halt_cause_q <= CAUSE_NONE;
        end else begin
            has_input_q <= transfer;
            case (state_q)
                WB_RUN: begin
                    if (fault) begin
                        state_q      <= WB_HALTED;
                        halt_pc_q    <= entry_q.pc;
                        halt_cause_q <= entry_cause;
                    end
                end
                WB_HALTED: begin
                    if (resume) begin
                        state_q      <= WB_RUN;
                        halt_cause_q <= CAUSE_NONE;
                    end
                end
                default: state_q <= WB_RUN;
            endcase
        end
    end

    retire_counter u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .count (retired_count)
    );

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: vector table, directed corner sequences, randomized run against a model.
module tb_writeback_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        resume;
    logic        rf_write_enable;
    logic [4:0]  rf_write_index;
    logic [31:0] rf_write_data;
    logic        fwd_valid;
    logic [4:0]  fwd_register;
    logic [31:0] fwd_data;
    logic [63:0] retired_count;
    logic        halted;
    logic [31:0] halt_pc;
    halt_cause_t halt_cause;

    writeback_stage_if bus ();

    writeback_stage dut (
        .clk             (clk),
        .rst             (rst),
        .mem             (bus),
        .resume          (resume),
        .rf_write_enable (rf_write_enable),
        .rf_write_index  (rf_write_index),
        .rf_write_data   (rf_write_data),
        .fwd_valid       (fwd_valid),
        .fwd_register    (fwd_register),
        .fwd_data        (fwd_data),
        .retired_count   (retired_count),
        .halted          (halted),
        .halt_pc         (halt_pc),
        .halt_cause      (halt_cause)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.prev_done               = 1'b0;
        bus.program_count_in        = '0;
        bus.program_count_valid_in  = 1'b0;
        bus.opcode_legal_in         = 1'b1;
        bus.environment_in          = 1'b0;
        bus.load_in                 = 1'b0;
        bus.store_in                = 1'b0;
        bus.write_register_in       = '0;
        bus.write_register_valid_in = 1'b0;
        bus.result_data_in          = '0;
        bus.result_data_valid_in    = 1'b0;
    endtask

    task automatic offer(input logic [31:0] pc, input logic legal, input logic env,
                         input logic wv, input logic [4:0] idx, input logic [31:0] data,
                         input logic dv);
        bus.prev_done               = 1'b1;
        bus.program_count_in        = pc;
        bus.program_count_valid_in  = 1'b1;
        bus.opcode_legal_in         = legal;
        bus.environment_in          = env;
        bus.load_in                 = 1'b0;
        bus.store_in                = !wv;
        bus.write_register_in       = idx;
        bus.write_register_valid_in = wv;
        bus.result_data_in          = data;
        bus.result_data_valid_in    = dv;
    endtask

    typedef struct {
        logic        legal;
        logic        env;
        logic        wv;
        logic [4:0]  idx;
        logic [31:0] data;
        logic        dv;
        logic        exp_we;
        halt_cause_t exp_cause;
    } vec_t;

    vec_t vecs[11];

    // Reference model state for the randomized run
    logic        m_rst, m_halted, m_has;
    logic        m_legal, m_env, m_wv, m_dv;
    logic [4:0]  m_idx;
    logic [31:0] m_data, m_pc, m_hpc;
    logic [63:0] m_count;
    halt_cause_t m_cause;

    function automatic halt_cause_t model_cause(input logic legal, input logic env,
                                                input logic wv, input logic dv);
        halt_cause_t c;
        c = CAUSE_NONE;
        if (wv && !dv) c = CAUSE_MISSING_DATA;
        if (env)       c = CAUSE_ENVIRONMENT;
        if (!legal)    c = CAUSE_ILLEGAL;
        return c;
    endfunction

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 5'd5,  32'h0000_002A, 1'b1, 1'b1, CAUSE_NONE};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 5'd0,  32'hFFFF_FFFF, 1'b1, 1'b0, CAUSE_NONE};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 5'd3,  32'h1234_5678, 1'b1, 1'b0, CAUSE_NONE};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd4,  32'h0000_0004, 1'b1, 1'b0, CAUSE_ILLEGAL};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'd0,  32'h0000_0000, 1'b0, 1'b0, CAUSE_ENVIRONMENT};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 5'd6,  32'h0000_0066, 1'b0, 1'b0, CAUSE_MISSING_DATA};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 5'd7,  32'h0000_0077, 1'b0, 1'b0, CAUSE_ILLEGAL};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 5'd8,  32'h0000_0088, 1'b0, 1'b0, CAUSE_ENVIRONMENT};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b1, CAUSE_NONE};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 5'd0,  32'h0000_0001, 1'b0, 1'b0, CAUSE_MISSING_DATA};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 5'd9,  32'h0000_0009, 1'b0, 1'b0, CAUSE_NONE};

        rst = 1'b1;
        resume = 1'b0;
        drive_idle();
        exp_count = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_stall", 64'(bus.stall_prev), 64'd1);
        check("rst_we", 64'(rf_write_enable), 64'd0);
        check("rst_fwd", 64'(fwd_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_count", retired_count, 64'd0);
        check("reset_stall", 64'(bus.stall_prev), 64'd0);
        check("reset_cause", 64'(halt_cause), 64'(CAUSE_NONE));
        check("reset_hpc", 64'(halt_pc), 64'd0);

        // Vector table: one offer, then observe write, halt and retire effects
        for (int i = 0; i < 11; i++) begin
            logic [31:0] pc;
            logic        is_fault;
            pc = 32'(32'h200 + i * 4);
            is_fault = (vecs[i].exp_cause != CAUSE_NONE);
            offer(pc, vecs[i].legal, vecs[i].env, vecs[i].wv, vecs[i].idx, vecs[i].data, vecs[i].dv);
            @(negedge clk);
            drive_idle();
            check($sformatf("vec%0d_we", i), 64'(rf_write_enable), 64'(vecs[i].exp_we));
            check($sformatf("vec%0d_fwd_valid", i), 64'(fwd_valid), 64'(vecs[i].exp_we));
            check($sformatf("vec%0d_stall", i), 64'(bus.stall_prev), 64'(is_fault));
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_idx", i), 64'(rf_write_index), 64'(vecs[i].idx));
                check($sformatf("vec%0d_data", i), 64'(rf_write_data), 64'(vecs[i].data));
                check($sformatf("vec%0d_fwd_reg", i), 64'(fwd_register), 64'(vecs[i].idx));
                check($sformatf("vec%0d_fwd_data", i), 64'(fwd_data), 64'(vecs[i].data));
            end
            @(negedge clk);
            if (!is_fault) exp_count = exp_count + 1;
            check($sformatf("vec%0d_count", i), retired_count, exp_count);
            check($sformatf("vec%0d_halted", i), 64'(halted), 64'(is_fault));
            check($sformatf("vec%0d_cause", i), 64'(halt_cause), 64'(vecs[i].exp_cause));
            if (is_fault) begin
                check($sformatf("vec%0d_hpc", i), 64'(halt_pc), 64'(pc));
                resume = 1'b1;
                @(negedge clk);
                resume = 1'b0;
                check($sformatf("vec%0d_resumed", i), 64'(halted), 64'd0);
                check($sformatf("vec%0d_cause_clr", i), 64'(halt_cause), 64'(CAUSE_NONE));
            end
        end

        // Illegal at 0x100 followed immediately by another offer
        offer(32'h100, 1'b0, 1'b0, 1'b1, 5'd2, 32'h22, 1'b1);
        @(negedge clk);
        check("ill_stall_fault_cycle", 64'(bus.stall_prev), 64'd1);
        check("ill_we", 64'(rf_write_enable), 64'd0);
        offer(32'h104, 1'b1, 1'b0, 1'b1, 5'd7, 32'h77, 1'b1);
        @(negedge clk);
        check("ill_halted", 64'(halted), 64'd1);
        check("ill_hpc", 64'(halt_pc), 64'h100);
        check("ill_cause", 64'(halt_cause), 64'(CAUSE_ILLEGAL));
        check("ill_count", retired_count, exp_count);
        check("ill_stall_halted", 64'(bus.stall_prev), 64'd1);
        check("ill_no_entry", 64'(rf_write_enable), 64'd0);
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        check("ill_resumed", 64'(halted), 64'd0);
        check("ill_cause_none", 64'(halt_cause), 64'(CAUSE_NONE));
        check("ill_hpc_hold", 64'(halt_pc), 64'h100);
        check("ill_stall_low", 64'(bus.stall_prev), 64'd0);
        check("ill_refused_not_held", 64'(rf_write_enable), 64'd0);
        @(negedge clk);
        drive_idle();
        check("ill_next_we", 64'(rf_write_enable), 64'd1);
        check("ill_next_idx", 64'(rf_write_index), 64'd7);
        check("ill_next_data", 64'(rf_write_data), 64'h77);
        @(negedge clk);
        exp_count = exp_count + 1;
        check("ill_next_count", retired_count, exp_count);

        // Eight back-to-back transfers
        for (int i = 0; i < 8; i++) begin
            offer(32'(32'h400 + i * 4), 1'b1, 1'b0, 1'b1, 5'(i + 1), 32'(i * 3 + 1), 1'b1);
            @(negedge clk);
            check($sformatf("b2b%0d_stall", i), 64'(bus.stall_prev), 64'd0);
            check($sformatf("b2b%0d_we", i), 64'(rf_write_enable), 64'd1);
            check($sformatf("b2b%0d_idx", i), 64'(rf_write_index), 64'(i + 1));
            check($sformatf("b2b%0d_data", i), 64'(rf_write_data), 64'(i * 3 + 1));
        end
        drive_idle();
        @(negedge clk);
        exp_count = exp_count + 8;
        check("b2b_count", retired_count, exp_count);

        // Reset while an entry is held
        offer(32'h500, 1'b1, 1'b0, 1'b1, 5'd9, 32'h99, 1'b1);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        #1;
        check("rstmid_stall", 64'(bus.stall_prev), 64'd1);
        check("rstmid_we", 64'(rf_write_enable), 64'd0);
        check("rstmid_fwd", 64'(fwd_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_count = '0;
        check("rstmid_count", retired_count, exp_count);
        check("rstmid_we_after", 64'(rf_write_enable), 64'd0);

        // Counter wrap from all ones
        force dut.u_retire_counter.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.u_retire_counter.count_q;
        offer(32'h600, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        check("wrap_count", retired_count, 64'd0);

        // Randomized run against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_rst = 1'b0; m_halted = 1'b0; m_has = 1'b0; m_count = '0;
        m_hpc = '0; m_cause = CAUSE_NONE;
        m_legal = 1'b1; m_env = 1'b0; m_wv = 1'b0; m_dv = 1'b0;
        m_idx = '0; m_data = '0; m_pc = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            halt_cause_t c;
            logic flt, e_stall, e_we, r_rst, r_pd, r_res, acc;
            logic r_legal, r_env, r_wv, r_dv;
            logic [4:0]  r_idx;
            logic [31:0] r_data, r_pc;
            @(negedge clk);
            c = model_cause(m_legal, m_env, m_wv, m_dv);
            flt = m_has && (c != CAUSE_NONE);
            e_stall = m_rst || m_halted || flt;
            e_we = !m_rst && !m_halted && m_has && !flt && m_wv && (m_idx != 5'd0);
            check("rnd_stall", 64'(bus.stall_prev), 64'(e_stall));
            check("rnd_we", 64'(rf_write_enable), 64'(e_we));
            check("rnd_fwd_valid", 64'(fwd_valid), 64'(e_we));
            if (e_we) begin
                check("rnd_idx", 64'(rf_write_index), 64'(m_idx));
                check("rnd_data", 64'(rf_write_data), 64'(m_data));
                check("rnd_fwd_data", 64'(fwd_data), 64'(m_data));
            end
            check("rnd_halted", 64'(halted), 64'(!m_rst && m_halted));
            check("rnd_cause", 64'(halt_cause), 64'(m_cause));
            check("rnd_hpc", 64'(halt_pc), 64'(m_hpc));
            check("rnd_count", retired_count, m_count);

            r_rst   = ($urandom_range(0, 99) < 2);
            r_pd    = ($urandom_range(0, 9) < 7);
            r_legal = ($urandom_range(0, 19) != 0);
            r_env   = ($urandom_range(0, 24) == 0);
            r_wv    = ($urandom_range(0, 9) < 7);
            r_dv    = ($urandom_range(0, 11) != 0);
            r_idx   = 5'($urandom_range(0, 31));
            r_data  = $urandom;
            r_pc    = $urandom;
            r_res   = ($urandom_range(0, 7) == 0);
            rst = r_rst;
            resume = r_res;
            offer(r_pc, r_legal, r_env, r_wv, r_idx, r_data, r_dv);
            bus.prev_done = r_pd;

            acc = r_pd && !(r_rst || m_halted || flt);
            if (r_rst) begin
                m_halted = 1'b0; m_has = 1'b0; m_count = '0;
                m_hpc = '0; m_cause = CAUSE_NONE;
            end else begin
                if (!m_halted && m_has && !flt) m_count = m_count + 1;
                if (m_halted) begin
                    if (r_res) begin
                        m_halted = 1'b0;
                        m_cause = CAUSE_NONE;
                    end
                end else if (flt) begin
                    m_halted = 1'b1;
                    m_hpc = m_pc;
                    m_cause = c;
                end
                m_has = acc;
                if (acc) begin
                    m_legal = r_legal; m_env = r_env; m_wv = r_wv; m_dv = r_dv;
                    m_idx = r_idx; m_data = r_data; m_pc = r_pc;
                end
            end
            m_rst = r_rst;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
